// File: rtl/btn_click_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : btn_click_classifier
//  Description : Splits debounced presses into single and double clicks using
//                a programmable window, with pulse outputs and BCD tallies.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_click_classifier #(
    parameter int WINDOW = 25_000_000,
    parameter int TMR_W  = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_pulse,
    output logic             single_out,
    output logic             double_out,
    output logic             busy,
    output logic [3:0]       single_cnt,
    output logic [3:0]       double_cnt
);

    localparam logic [0:0]       S_IDLE     = 1'b0;
    localparam logic [0:0]       S_WAIT     = 1'b1;
    localparam logic [TMR_W-1:0] c_WINDOW   = TMR_W'(WINDOW);
    localparam logic [TMR_W-1:0] c_TMR_ONE  = TMR_W'(1);

    logic [0:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_single;
    logic             r_double;
    logic             r_busy;
    logic [3:0]       r_single_cnt;
    logic [3:0]       r_double_cnt;

    // Decimal digit increment, 9 rolls over to 0 without carry.
    function automatic logic [3:0] bcd_inc(input logic [3:0] v);
        return (v == 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_single     <= 1'b0;
            r_double     <= 1'b0;
            r_busy       <= 1'b0;
            r_single_cnt <= 4'd0;
            r_double_cnt <= 4'd0;
        end else begin
            r_single <= 1'b0;
            r_double <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (btn_pulse) begin
                        r_timer <= c_WINDOW;
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // A second press beats expiry, even on the last window cycle.
                    if (btn_pulse) begin
                        r_double     <= 1'b1;
                        r_double_cnt <= bcd_inc(r_double_cnt);
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else if (r_timer == c_TMR_ONE) begin
                        r_single     <= 1'b1;
                        r_single_cnt <= bcd_inc(r_single_cnt);
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else begin
                        r_timer <= r_timer - c_TMR_ONE;
                    end
                end
            endcase
        end
    end

    assign single_out = r_single;
    assign double_out = r_double;
    assign busy       = r_busy;
    assign single_cnt = r_single_cnt;
    assign double_cnt = r_double_cnt;

endmodule
`default_nettype wire

// File: tb/tb_btn_click_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_click_classifier
//  Description : Scoreboard bench for btn_click_classifier with a time-based
//                reference model of click classification.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_click_classifier;

    localparam int WINDOW = 8;
    localparam int TMR_W  = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_pulse;
    logic       single_out;
    logic       double_out;
    logic       busy;
    logic [3:0] single_cnt;
    logic [3:0] double_cnt;

    btn_click_classifier #(.WINDOW(WINDOW), .TMR_W(TMR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_pulse  (btn_pulse),
        .single_out (single_out),
        .double_out (double_out),
        .busy       (busy),
        .single_cnt (single_cnt),
        .double_cnt (double_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_double;
        logic [3:0] sc;
        logic [3:0] dc;
    } exp_t;

    exp_t q[$];
    exp_t e_pop;
    int   checks = 0;
    int   errors = 0;

    // Reference: a window is an open interval measured in sampled edges.
    int cyc  = 0;
    int t0   = 0;
    bit open = 0;
    int sc   = 0;
    int dc   = 0;

    function automatic void model(input bit b);
        cyc++;
        if (!open) begin
            if (b) begin
                open = 1;
                t0   = cyc;
            end
        end else if (b) begin
            dc   = (dc + 1) % 10;
            q.push_back('{1'b1, 4'(sc), 4'(dc)});
            open = 0;
        end else if (cyc - t0 == WINDOW) begin
            sc   = (sc + 1) % 10;
            q.push_back('{1'b0, 4'(sc), 4'(dc)});
            open = 0;
        end
    endfunction

    task automatic step(input bit b);
        @(negedge clk);
        btn_pulse = b;
        model(b);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== open || single_cnt !== 4'(sc) || double_cnt !== 4'(dc)) begin
            errors++;
            $display("FAIL state cyc=%0d busy=%b/%b scnt=%0d/%0d dcnt=%0d/%0d (actual/required)",
                     cyc, busy, open, single_cnt, sc, double_cnt, dc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (single_out !== 1'b0 || double_out !== 1'b0 || busy !== 1'b0 ||
            single_cnt !== 4'd0 || double_cnt !== 4'd0) begin
            errors++;
            $display("FAIL %s so=%b do=%b busy=%b scnt=%0d dcnt=%0d required all 0",
                     name, single_out, double_out, busy, single_cnt, double_cnt);
        end
    endtask

    task automatic model_reset();
        open = 0;
        sc   = 0;
        dc   = 0;
        q.delete();
    endtask

    // Monitor: every decision pulse must match the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (single_out && double_out) begin
                checks++;
                errors++;
                $display("FAIL both_pulses so=%b do=%b required at most one high", single_out, double_out);
            end else if (single_out || double_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event so=%b do=%b required no event", single_out, double_out);
                end else begin
                    e_pop = q.pop_front();
                    if (double_out !== e_pop.is_double || single_cnt !== e_pop.sc ||
                        double_cnt !== e_pop.dc) begin
                        errors++;
                        $display("FAIL event dbl=%b/%b scnt=%0d/%0d dcnt=%0d/%0d (actual/required)",
                                 double_out, e_pop.is_double, single_cnt, e_pop.sc,
                                 double_cnt, e_pop.dc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish required completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        btn_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        idle(20);

        // Single click, then boundary double clicks (gap 1 and gap WINDOW)
        step(1'b1); idle(12);
        step(1'b1); step(1'b1); idle(5);
        step(1'b1); idle(WINDOW - 1); step(1'b1); idle(5);
        // Gap WINDOW+1: single, then the late pulse opens a new window
        step(1'b1); idle(WINDOW); step(1'b1); idle(WINDOW + 3);

        // Counter wrap: ten singles then ten doubles
        for (int i = 0; i < 10; i++) begin
            step(1'b1); idle(WINDOW + 2);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1); idle(1 + (i % 3)); step(1'b1); idle(3);
        end

        // Back-to-back stream 10, 12, 14
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1); idle(WINDOW + 3);

        // Asynchronous reset mid-window
        step(1'b1); idle(3);
        #3;
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(WINDOW + 5);

        // Randomized presses with varied gaps
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            step(1'b1);
            idle($urandom_range(0, WINDOW + 2));
        end
        idle(WINDOW + 3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_click_classifier.md
Name: btn_click_classifier

Overview:
- Sits directly downstream of the button debouncer/one-shot stage and consumes its 1-cycle press pulse.
- Classifies each press as a single click or a double click using a programmable time window.
- Emits 1-cycle event pulses for each class.
- Keeps wrap-around BCD tallies of each class for the seven-segment display logic.

Parameters:
- WINDOW, 25_000_000: cycles after a first press during which a second press counts as a double click; legal range is WINDOW >= 2.
- TMR_W, 25: width of the window timer; must satisfy 2**TMR_W > WINDOW.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_pulse  input  1  debounced press pulse from the upstream stage; synchronous to clk; high for exactly 1 cycle per press.
- single_out  output  1  high for 1 cycle when a single click is decided.
- double_out  output  1  high for 1 cycle when a double click is decided.
- busy  output  1  high while a window is open (state WAIT).
- single_cnt  output  4  BCD count of single clicks, 0..9, wraps.
- double_cnt  output  4  BCD count of double clicks, 0..9, wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, timer = 0.
  - single_out = 0, double_out = 0, busy = 0.
  - single_cnt = 0, double_cnt = 0.
  - Reset acts immediately regardless of clk. Asserting it mid-window discards the pending click and emits no pulse.
- All outputs are registered. single_out and double_out default to 0 every cycle unless set by a decision below.
- FSM has 2 states.
- IDLE:
  - On btn_pulse = 1: timer <= WINDOW; state <= WAIT.
  - Otherwise: stay in IDLE.
- WAIT (busy = 1):
  - Priority 1, btn_pulse = 1: double_out <= 1; double_cnt <= BCD increment; state <= IDLE.
  - Priority 2, btn_pulse = 0 and timer == 1: single_out <= 1; single_cnt <= BCD increment; state <= IDLE.
  - Otherwise: timer <= timer - 1.
- Window timing: let the first pulse be sampled at edge t.
  - A second pulse sampled at any edge t+1 .. t+WINDOW produces a double click.
  - With no second pulse, single_out is high in the cycle after edge t+WINDOW.
  - A decision pulse appears in the cycle following the deciding edge, i.e. 1-cycle latency.
- Simultaneous events:
  - A pulse at exactly edge t+WINDOW (timer == 1) counts as a double; the pulse wins over expiry.
  - A pulse arriving in the same edge that returns the FSM to IDLE is consumed by that decision. It does not start a new window.
  - A third press is handled as the first press of a new window, since the FSM is in IDLE by then.
- BCD increment: 9 -> 0 with no carry out; every other value increments by 1. single_cnt and double_cnt are independent.
- At most one of single_out / double_out is high in any cycle.

Test Plan (WINDOW=8 for simulation):
- Reset and idle: hold rst_n=0 for 3 cycles, then release with no btn_pulse for 20 cycles -> all outputs 0 throughout, busy = 0.
- Single click: 1 pulse at edge 10 -> busy = 1 from after edge 10 through edge 18. single_out is high in exactly the cycle after edge 18. single_cnt = 1, double_out never asserted.
- Double click at the boundaries: pulses at edges 10 and 11 -> double_out high after edge 11, double_cnt = 1. Repeat with pulses at edges 30 and 38 -> double_cnt = 2. Pulses at edges 50 and 59 -> single_out after edge 58, and the edge-59 pulse opens a new window.
- Counter wrap: 10 single clicks -> single_cnt runs 1..9 then 0, and double_cnt is unchanged. 10 double clicks -> double_cnt wraps to 0 the same way.
- Reset mid-window: pulse at edge 10, then drive rst_n low between edges 13 and 14 -> outputs clear immediately. After release, no single_out or double_out appears and the counters read 0.
- Back-to-back stream: pulses at edges 10, 12 and 14 -> double after edge 12. The edge-14 pulse starts a new window, giving single_out after edge 22. Final values: double_cnt = 1, single_cnt = 1.
